// File: rtl/avalon_copy_master_if.sv
// Word-addressed Avalon-MM bus between the copy master and a slave.
// Request fields come from the master and stay stable while av_waitrequest is high.
interface avalon_copy_master_if;
  logic [29:0] av_addr;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        av_waitrequest;

  modport master (
    output av_addr, av_read, av_write, av_writedata,
    input  av_readdata, av_waitrequest
  );

  modport slave (
    input  av_addr, av_read, av_write, av_writedata,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/avalon_copy_master.sv
// Avalon-MM block copier: one word per 2+READ_LATENCY cycles, one read outstanding.
// Stalls in READ/WRITE while av_waitrequest is high; bus outputs are decoded from registers only.
module avalon_copy_master #(
  parameter int READ_LATENCY = 1,
  parameter int LEN_BITS     = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Start,
  input  logic [29:0]         i_SrcAddr,
  input  logic [29:0]         i_DstAddr,
  input  logic [LEN_BITS-1:0] i_Len,
  output logic                o_Busy,
  output logic                o_Done,
  avalon_copy_master_if.master av
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_RDWAIT, S_WRITE, S_DONE} state_t;

  localparam logic [2:0]          LAT     = 3'(READ_LATENCY);
  localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);

  state_t              r_state, w_state;
  logic [29:0]         r_src, w_src;
  logic [29:0]         r_dst, w_dst;
  logic [LEN_BITS-1:0] r_rem, w_rem;
  logic [31:0]         r_data, w_data;
  logic [2:0]          r_lat, w_lat;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state;
      r_src   <= w_src;
      r_dst   <= w_dst;
      r_rem   <= w_rem;
      r_data  <= w_data;
      r_lat   <= w_lat;
    end
  end

  always_comb begin
    w_state         = r_state;
    w_src           = r_src;
    w_dst           = r_dst;
    w_rem           = r_rem;
    w_data          = r_data;
    w_lat           = r_lat;
    o_Busy          = 1'b1;
    o_Done          = 1'b0;
    av.av_read      = 1'b0;
    av.av_write     = 1'b0;
    av.av_addr      = '0;
    av.av_writedata = '0;

    unique case (r_state)
      S_IDLE: begin
        o_Busy = 1'b0;
        if (i_Start) begin
          w_src   = i_SrcAddr;
          w_dst   = i_DstAddr;
          w_rem   = i_Len;
          w_state = (i_Len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        av.av_read = 1'b1;
        av.av_addr = r_src;
        if (!av.av_waitrequest) begin
          w_lat   = LAT;
          w_state = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        // Slave data is valid on the edge where the countdown sits at 1.
        w_lat = r_lat - 3'd1;
        if (r_lat == 3'd1) begin
          w_data  = av.av_readdata;
          w_state = S_WRITE;
        end
      end
      S_WRITE: begin
        av.av_write     = 1'b1;
        av.av_addr      = r_dst;
        av.av_writedata = r_data;
        if (!av.av_waitrequest) begin
          w_src   = r_src + 30'd1;
          w_dst   = r_dst + 30'd1;
          w_rem   = r_rem - LEN_ONE;
          w_state = (r_rem == LEN_ONE) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        o_Done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end
endmodule
